// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with anti-ghost blanking and frame-synchronous data commit.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
   parameter int TICK_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] din,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  dig_en,
   output logic        ld_ack,
   output logic [3:0]  an,
   output logic [3:0]  hex,
   output logic        blank,
   output logic        dp_n,
   output logic        dbg_state
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX    = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] SHOW_START = CW'(BLANK_CYC - 1);

   typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   disp_q, disp_d, pend_data_q, pend_data_d;
   logic [3:0]    disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic          pend_q, pend_d;
   logic          ld_ack_q, ld_ack_d;
   logic [3:0]    an_q, an_d, hex_q, hex_d;
   logic          blank_q, blank_d, dp_n_q, dp_n_d;
   logic          last_slot, frame_end, lzb_blank, digit_on;

`ifdef SEG_SCAN_LZB_EN
   // A digit is a leading zero when it and every digit to its left are zero and it carries no point.
   always_comb begin
      lzb_blank = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'h0000)
                  && !disp_dp_q[idx_q];
   end
`else
   assign lzb_blank = 1'b0;
`endif

   always_comb begin
      last_slot = (cnt_q == CNT_MAX);
      frame_end = last_slot && (idx_q == 2'd3);
      cnt_d     = last_slot ? '0 : cnt_q + 1'b1;
      idx_d     = last_slot ? idx_q + 2'd1 : idx_q;

      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_q == SHOW_START) state_d = ST_SHOW;
         ST_SHOW:  if (last_slot) state_d = ST_BLANK;
         default:  state_d = ST_BLANK;
      endcase

      // A load in the boundary cycle itself wins over anything already pending.
      disp_d      = disp_q;
      disp_dp_d   = disp_dp_q;
      pend_d      = pend_q;
      pend_data_d = pend_data_q;
      pend_dp_d   = pend_dp_q;
      ld_ack_d    = 1'b0;
      if (frame_end) begin
         if (load) begin
            disp_d    = din;
            disp_dp_d = dp_in;
            pend_d    = 1'b0;
            ld_ack_d  = 1'b1;
         end else if (pend_q) begin
            disp_d    = pend_data_q;
            disp_dp_d = pend_dp_q;
            pend_d    = 1'b0;
            ld_ack_d  = 1'b1;
         end
      end else if (load) begin
         pend_data_d = din;
         pend_dp_d   = dp_in;
         pend_d      = 1'b1;
      end

      digit_on = (state_q == ST_SHOW) && dig_en[idx_q] && !lzb_blank;
      an_d     = digit_on ? ~(4'b0001 << idx_q) : 4'hF;
      hex_d    = digit_on ? disp_q[{idx_q, 2'b00} +: 4] : 4'h0;
      blank_d  = !digit_on;
      dp_n_d   = digit_on ? ~disp_dp_q[idx_q] : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_BLANK;
         cnt_q       <= '0;
         idx_q       <= 2'd0;
         disp_q      <= 16'h0000;
         disp_dp_q   <= 4'h0;
         pend_q      <= 1'b0;
         pend_data_q <= 16'h0000;
         pend_dp_q   <= 4'h0;
         ld_ack_q    <= 1'b0;
         an_q        <= 4'hF;
         hex_q       <= 4'h0;
         blank_q     <= 1'b1;
         dp_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         disp_q      <= disp_d;
         disp_dp_q   <= disp_dp_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         pend_dp_q   <= pend_dp_d;
         ld_ack_q    <= ld_ack_d;
         an_q        <= an_d;
         hex_q       <= hex_d;
         blank_q     <= blank_d;
         dp_n_q      <= dp_n_d;
      end
   end

   assign ld_ack    = ld_ack_q;
   assign an        = an_q;
   assign hex       = hex_q;
   assign blank     = blank_q;
   assign dp_n      = dp_n_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (TICK_DIV=8, BLANK_CYC=2): frame-position reference model checked every cycle,
// a table of display patterns checked mid-slot, and directed load/reset sequences.
module tb_seg_scan_ctrl;

   localparam int TD = 8;
   localparam int BC = 2;
   localparam int FRAME = 4 * TD;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  dig_en;
   logic        ld_ack;
   logic [3:0]  an;
   logic [3:0]  hex;
   logic        blank;
   logic        dp_n;
   logic        dbg_state;

   seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in), .dig_en(dig_en),
      .ld_ack(ld_ack), .an(an), .hex(hex), .blank(blank), .dp_n(dp_n), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: position in the scan is just the number of clock edges since reset release.
   int          n = 0;
   int          shown_pos = -1;
   logic [15:0] disp_m = 16'h0, pd = 16'h0;
   logic [3:0]  dpm = 4'h0, pdp = 4'h0;
   logic        pend_m = 1'b0;
   int          ack_cnt = 0;
   logic        a_seen = 1'b0;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (n=%0d)", nm, got, exp, n);
      end
   endtask

   function automatic logic lzb_m(input int d, input logic [15:0] dv, input logic [3:0] dpv);
`ifdef SEG_SCAN_LZB_EN
      return (d > 0) && ((dv >> (4 * d)) == 16'h0) && !dpv[d];
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      int slot, dig;
      logic e_on, e_ack;
      logic [3:0] e_an, e_hex;
      logic e_dpn;
      @(posedge clk);
      slot  = n % TD;
      dig   = (n / TD) % 4;
      e_on  = (slot >= BC) && dig_en[dig] && !lzb_m(dig, disp_m, dpm);
      e_an  = e_on ? ~(4'b0001 << dig) : 4'hF;
      e_hex = 4'((disp_m >> (4 * dig)) & 16'hF);
      e_dpn = e_on ? ~dpm[dig] : 1'b1;
      e_ack = 1'b0;
      if (n % FRAME == FRAME - 1) begin
         if (load) begin
            disp_m = din; dpm = dp_in; pend_m = 1'b0; e_ack = 1'b1;
         end else if (pend_m) begin
            disp_m = pd; dpm = pdp; pend_m = 1'b0; e_ack = 1'b1;
         end
      end else if (load) begin
         pd = din; pdp = dp_in; pend_m = 1'b1;
      end
      shown_pos = n;
      n++;
      #1;
      chk("m_an", 16'(an), 16'(e_an));
      chk("m_blank", 16'(blank), 16'(!e_on));
      chk("m_dp_n", 16'(dp_n), 16'(e_dpn));
      chk("m_ld_ack", 16'(ld_ack), 16'(e_ack));
      if (e_on) chk("m_hex", 16'(hex), 16'(e_hex));
      if (ld_ack) ack_cnt++;
      if (!blank && hex == 4'hA) a_seen = 1'b1;
   endtask

   task automatic run_until_pos(input int p);
      for (int i = 0; i < 2 * FRAME && (shown_pos % FRAME) != p; i++) step();
      chk("wait_pos", 16'(shown_pos % FRAME), 16'(p));
   endtask

   task automatic run_until_n(input int p);
      for (int i = 0; i < 2 * FRAME && (n % FRAME) != p; i++) step();
      chk("wait_n", 16'(n % FRAME), 16'(p));
   endtask

   typedef struct {
      logic [15:0] din;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic [15:0] e_hex;
      logic [3:0]  e_dpn;
      logic [3:0]  e_on;
      logic [3:0]  e_on_lzb;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [3:0]  on, e_an;
      logic [15:0] beef;
      tbl[0] = '{16'h1234, 4'b0100, 4'hF,    16'h1234, 4'b1011, 4'b1111, 4'b1111};
      tbl[1] = '{16'h0070, 4'b0000, 4'hF,    16'h0070, 4'b1111, 4'b1111, 4'b0011};
      tbl[2] = '{16'h1234, 4'b0000, 4'b0101, 16'h1234, 4'b1111, 4'b0101, 4'b0101};
      tbl[3] = '{16'h0000, 4'b1000, 4'hF,    16'h0000, 4'b0111, 4'b1111, 4'b1001};
      tbl[4] = '{16'h00A0, 4'b0010, 4'b1110, 16'h00A0, 4'b1101, 4'b1110, 4'b0010};

      rst = 1'b1; load = 1'b0; din = 16'h0; dp_in = 4'h0; dig_en = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_hex", 16'(hex), 16'h0);
      chk("rst_blank", 16'(blank), 16'h1);
      chk("rst_dp_n", 16'(dp_n), 16'h1);
      chk("rst_ld_ack", 16'(ld_ack), 16'h0);
      rst = 1'b0;

      // First SHOW of digit 0 lands on the BLANK_CYC+1-th edge after release.
      step(); step();
      chk("first_blank", 16'(an), 16'hF);
      step();
      chk("first_show", 16'(an), 16'hE);

      foreach (tbl[k]) begin
         dig_en = tbl[k].en; din = tbl[k].din; dp_in = tbl[k].dp; load = 1'b1;
         step();
         load = 1'b0;
         run_until_n(0);
         chk("tbl_ack", 16'(ld_ack), 16'h1);
`ifdef SEG_SCAN_LZB_EN
         on = tbl[k].e_on_lzb;
`else
         on = tbl[k].e_on;
`endif
         for (int d = 0; d < 4; d++) begin
            run_until_pos(d * TD + 4);
            e_an = on[d] ? ~(4'b0001 << d) : 4'hF;
            chk("tbl_an", 16'(an), 16'(e_an));
            chk("tbl_dp_n", 16'(dp_n), 16'(on[d] ? tbl[k].e_dpn[d] : 1'b1));
            if (on[d]) chk("tbl_hex", 16'(hex), (tbl[k].e_hex >> (4 * d)) & 16'hF);
         end
      end

      // Two loads in one frame: only the later one becomes visible, with a single ack.
      dig_en = 4'hF;
      run_until_n(5);
      ack_cnt = 0;
      din = 16'hAAAA; dp_in = 4'h0; load = 1'b1; step(); load = 1'b0;
      repeat (3) step();
      din = 16'h5555; load = 1'b1; step(); load = 1'b0;
      run_until_n(0);
      a_seen = 1'b0;
      repeat (FRAME) step();
      chk("dbl_ack_cnt", 16'(ack_cnt), 16'h1);
      chk("dbl_no_aaaa", 16'(a_seen), 16'h0);

      // Load presented exactly in the frame-boundary cycle.
      run_until_n(FRAME - 1);
      din = 16'hBEEF; dp_in = 4'h0; load = 1'b1; step(); load = 1'b0;
      chk("bnd_ack", 16'(ld_ack), 16'h1);
      beef = 16'hBEEF;
      for (int d = 0; d < 4; d++) begin
         run_until_pos(d * TD + 4);
         chk("bnd_hex", 16'(hex), 16'(beef[4 * d +: 4]));
      end

      for (int i = 0; i < 600; i++) begin
         load  = ($urandom_range(0, 9) == 0);
         din   = 16'($urandom);
         dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) dig_en = 4'($urandom_range(0, 15));
         step();
      end
      load = 1'b0;
      dig_en = 4'hF;

      // Reset mid-SHOW of digit 2 with a load still pending.
      run_until_pos(2 * TD + 4);
      din = 16'h9876; dp_in = 4'hF; load = 1'b1; step(); load = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("arst_an", 16'(an), 16'hF);
      chk("arst_blank", 16'(blank), 16'h1);
      chk("arst_ack", 16'(ld_ack), 16'h0);
      @(posedge clk); @(posedge clk);
      #1;
      chk("rst_hold_an", 16'(an), 16'hF);
      chk("rst_hold_ack", 16'(ld_ack), 16'h0);
      rst = 1'b0;
      n = 0; shown_pos = -1; disp_m = 16'h0; dpm = 4'h0; pend_m = 1'b0;
      ack_cnt = 0;
      repeat (3 * FRAME) step();
      chk("post_rst_acks", 16'(ack_cnt), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 The block SHALL have parameter BLANK_CYC, default 16, meaning anti-ghost cycles at the start of each slot (legal range 1..TICK_DIV-2).
REQ-003 clk  input  1  system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 load  input  1  one-cycle strobe that presents new display data.
REQ-006 din  input  16  four hex nibbles; din[3:0] is digit 0, which is the rightmost digit.
REQ-007 dp_in  input  4  decimal-point request per digit, active-high.
REQ-008 dig_en  input  4  per-digit enable, active-high.
REQ-009 ld_ack  output  1  one-cycle pulse when new data becomes visible.
REQ-010 an  output  4  digit anodes, active-low, with at most one bit low.
REQ-011 hex  output  4  nibble sent to the 7-segment decoder.
REQ-012 blank  output  1  high means the decoder/segments are forced off.
REQ-013 dp_n  output  1  decimal point, active-low.

Function
REQ-014 The block SHALL keep a slot counter cnt that counts 0..TICK_DIV-1, wraps to 0 and advances digit index idx 0→1→2→3→0 on the wrap.
REQ-015 The state machine SHALL have two states: BLANK while cnt<BLANK_CYC, and SHOW while BLANK_CYC<=cnt<=TICK_DIV-1; the transition SHOW→BLANK SHALL coincide with the cnt wrap.
REQ-016 In BLANK, outputs SHALL be an=4'b1111, blank=1 and dp_n=1.
REQ-017 In SHOW, outputs SHALL be an[idx]=0 with the other bits 1, hex=disp[4*idx+3:4*idx], dp_n=~disp_dp[idx] and blank=0.
REQ-018 In SHOW, if dig_en[idx]=0 the outputs SHALL be as in BLANK for the whole slot; the slot timing SHALL be unchanged.
REQ-019 On load=1, din and dp_in SHALL be captured into pending registers and a pend flag SHALL be set; a later load before commit SHALL overwrite the pending data.
REQ-020 Commit SHALL occur only at the frame boundary (idx=3 and cnt=TICK_DIV-1): if pend=1, pending is copied to disp/disp_dp, pend is cleared and ld_ack=1 for exactly the next cycle.
REQ-021 If load=1 in the frame-boundary cycle, din/dp_in SHALL commit directly in that cycle, take precedence over the older pending data, and assert ld_ack.
REQ-022 Outputs SHALL be registered, giving one cycle of latency from the state/cnt decision to the pins, and SHALL be glitch-free.
REQ-023 The scan SHALL never stall: load and dig_en SHALL NOT alter cnt or idx.

Reset
REQ-024 While rst=1 the block SHALL force cnt=0, idx=0, state=BLANK, an=4'b1111, hex=0, blank=1, dp_n=1, ld_ack=0, disp=0, disp_dp=0 and pend=0.
REQ-025 Reset asserted mid-slot or between load and commit SHALL discard pending data, and SHALL NOT pulse ld_ack.
REQ-026 After rst falls, the first SHOW SHALL be digit 0, starting at cycle BLANK_CYC+1, which includes the output register.

Configuration
REQ-027 When macro SEG_SCAN_LZB_EN is defined, the block SHALL apply leading-zero blanking: in SHOW, digit i>0 is blanked (blank=1, an all 1) when disp nibbles i..3 are all zero and disp_dp[i]=0; digit 0 is never blanked.
REQ-028 When SEG_SCAN_LZB_EN is undefined, all enabled digits SHALL be displayed, including leading zeros, and no blanking logic SHALL be synthesised.

Verification (TICK_DIV=8, BLANK_CYC=2 on the bench)
REQ-029 Release reset, load din=16'h1234, dp_in=4'b0100, dig_en=4'hF → ld_ack 1 cycle after the first frame boundary; next frame shows an=1110/hex=4, 1101/3, 1011/2 with dp_n=0, then 0111/1; each SHOW window lasts 6 cycles and is preceded by 2 cycles of an=1111.
REQ-030 Two loads in one frame (16'hAAAA then 16'h5555) → single ld_ack; display shows 5555 and never AAAA.
REQ-031 Load din=16'hBEEF exactly on the frame-boundary cycle → ld_ack on the next cycle; the next frame shows F,E,E,B.
REQ-032 dig_en=4'b0101 with disp=16'h1234 → an never drives digits 1 or 3 low; the frame period stays 32 cycles.
REQ-033 Assert rst at mid-SHOW of digit 2 with a load pending → an=1111 immediately (asynchronous), no ld_ack, disp=0 after release.
REQ-034 With SEG_SCAN_LZB_EN defined and disp=16'h0070 → digits 3 and 2 are blanked while 7 and 0 show; without the macro, 0,0,7,0 all show.
